// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if
// ----------------------------------------------------------------------------
// Bundle of every handshake/bus signal around mem_arbiter: the IF fetch
// requester, the M load/store requester and the unified memory port.
//   slave  : arbiter view (requests and memory responses in, grants out)
//   master : environment view (drives requests and memory responses)
// Signal names keep the _i/_o suffixes as seen from the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IF stage (read-only)
  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;
  // M stage (load/store)
  logic                  m_req_i;
  logic                  m_we_i;
  logic [DATA_W/8-1:0]   m_be_i;
  logic [ADDR_W-1:0]     m_addr_i;
  logic [DATA_W-1:0]     m_wdata_i;
  logic                  m_gnt_o;
  logic                  m_rvalid_o;
  logic [DATA_W-1:0]     m_rdata_o;
  // Unified memory port
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [DATA_W/8-1:0]   mem_be_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// ----------------------------------------------------------------------------
// Shares one memory port between the IF stage (fetch) and the M stage
// (load/store). M wins by default; after STARVE_MAX consecutive M grants
// taken while IF was waiting, IF is forced to win. At most one transaction
// is outstanding and its response is routed back to the requester owning it.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active low
//   bus   : mem_arbiter_if.slave (IF, M and memory signal groups)
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);

  localparam int BE_W = DATA_W / 8;

  // Requester encoding used for both the pending selection and the owner
  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_M  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t      state;
  logic        sel_q;       // selection frozen while waiting for mem_gnt_i
  logic        owner_q;     // requester owning the outstanding transaction
  logic [3:0]  starve_cnt;  // M grants taken while IF was waiting

  logic        starved;
  logic        req_any;
  logic        pick;        // fresh arbitration result, used only in IDLE
  logic        sel;
  logic        mem_req;
  logic        if_grant;
  logic        m_grant;
  logic        resp;

  always_comb begin
    starved = (starve_cnt == 4'(STARVE_MAX));
    req_any = bus.if_req_i | bus.m_req_i;
    // M wins unless IF is also asking and has been passed over too often
    pick    = (bus.m_req_i && !(bus.if_req_i && starved)) ? SEL_M : SEL_IF;
    mem_req = 1'b0;
    sel     = sel_q;
    unique case (state)
      IDLE: begin
        mem_req = req_any;
        sel     = pick;
      end
      HOLD: begin
        mem_req = 1'b1;
        sel     = sel_q;
      end
      default: begin
        mem_req = 1'b0;
        sel     = sel_q;
      end
    endcase
    if_grant = bus.mem_gnt_i && mem_req && (sel == SEL_IF);
    m_grant  = bus.mem_gnt_i && mem_req && (sel == SEL_M);
    // Responses count only while a transaction is outstanding
    resp     = (state == WAIT_RESP) && bus.mem_rvalid_i;
  end

  // Memory request fields; IF is always a full-word read, and every field
  // is zero while no request is presented.
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_req && (sel == SEL_M) && bus.m_we_i;
  assign bus.mem_be_o    = !mem_req ? '0 : ((sel == SEL_M) ? bus.m_be_i : {BE_W{1'b1}});
  assign bus.mem_addr_o  = !mem_req ? '0 : ((sel == SEL_M) ? bus.m_addr_i : bus.if_addr_i);
  assign bus.mem_wdata_o = (mem_req && (sel == SEL_M)) ? bus.m_wdata_i : '0;

  assign bus.if_gnt_o    = if_grant;
  assign bus.m_gnt_o     = m_grant;
  assign bus.if_rvalid_o = resp && (owner_q == SEL_IF);
  assign bus.m_rvalid_o  = resp && (owner_q == SEL_M);
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.m_rdata_o   = bus.mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      sel_q      <= SEL_IF;
      owner_q    <= SEL_IF;
      starve_cnt <= 4'd0;
    end else begin
      if (if_grant) begin
        starve_cnt <= 4'd0;
      end else if (m_grant && bus.if_req_i && (starve_cnt < 4'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      unique case (state)
        IDLE: begin
          if (req_any) begin
            sel_q <= pick;
            if (bus.mem_gnt_i) begin
              owner_q <= pick;
              state   <= WAIT_RESP;
            end else begin
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.mem_gnt_i) begin
            owner_q <= sel_q;
            state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (bus.mem_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter
// ----------------------------------------------------------------------------
// Directed stimulus for mem_arbiter. Expected memory requests and expected
// responses are queued as stimulus is issued; a monitor on the falling edge
// pops and compares them whenever the DUT grants or returns a response.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        owner_m;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  req_t        exp_req_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_m_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push_if(input logic [31:0] addr);
    exp_req_q.push_back('{owner_m: 1'b0, we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0});
  endtask

  task automatic push_m(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
    exp_req_q.push_back('{owner_m: 1'b1, we: we, be: be, addr: addr, wdata: wdata});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    req_t e;
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      if (exp_req_q.size() == 0) begin
        flag("unexpected_grant");
      end else begin
        e = exp_req_q.pop_front();
        chk("if_gnt",    32'(bus.if_gnt_o), 32'(!e.owner_m));
        chk("m_gnt",     32'(bus.m_gnt_o),  32'(e.owner_m));
        chk("mem_addr",  bus.mem_addr_o,    e.addr);
        chk("mem_we",    32'(bus.mem_we_o), 32'(e.we));
        chk("mem_be",    32'(bus.mem_be_o), 32'(e.be));
        chk("mem_wdata", bus.mem_wdata_o,   e.wdata);
      end
    end else if (bus.if_gnt_o || bus.m_gnt_o) begin
      flag("gnt_without_mem_gnt");
    end
    if (bus.if_rvalid_o) begin
      if (exp_if_q.size() == 0) flag("unexpected_if_rvalid");
      else chk("if_rdata", bus.if_rdata_o, exp_if_q.pop_front());
    end
    if (bus.m_rvalid_o) begin
      if (exp_m_q.size() == 0) flag("unexpected_m_rvalid");
      else chk("m_rdata", bus.m_rdata_o, exp_m_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // 1 = M expected to win, 0 = IF expected to win, with both requesting
  bit starve_vec [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [31:0] ia;
    logic [31:0] ma;
    bit later_if;
    bit later_m;

    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.m_req_i      = 1'b0;
    bus.m_we_i       = 1'b0;
    bus.m_be_i       = '0;
    bus.m_addr_i     = '0;
    bus.m_wdata_i    = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = '0;

    // ---- Reset state ----
    neg();
    chk("rst_if_gnt",    32'(bus.if_gnt_o),    32'h0);
    chk("rst_m_gnt",     32'(bus.m_gnt_o),     32'h0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("rst_m_rvalid",  32'(bus.m_rvalid_o),  32'h0);
    chk("rst_mem_req",   32'(bus.mem_req_o),   32'h0);
    step();
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    step();

    // ---- Single IF fetch ----
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; bus.mem_gnt_i = 1'b1;
    push_if(32'h100);
    neg();
    chk("t1_if_gnt", 32'(bus.if_gnt_o), 32'h1);
    chk("t1_mem_be", 32'(bus.mem_be_o), 32'hF);
    step();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    exp_if_q.push_back(32'hDEADBEEF);
    neg();
    chk("t1_m_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    step();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // ---- Simultaneous requests: M store first, then IF ----
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    bus.m_req_i = 1'b1; bus.m_we_i = 1'b1; bus.m_be_i = 4'h3;
    bus.m_addr_i = 32'h300; bus.m_wdata_i = 32'h12345678;
    bus.mem_gnt_i = 1'b1;
    push_m(1'b1, 4'h3, 32'h300, 32'h12345678);
    push_if(32'h200);
    step();
    bus.m_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
    exp_m_q.push_back(32'h0);
    step();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    step();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFEF00D;
    exp_if_q.push_back(32'hCAFEF00D);
    step();
    bus.mem_rvalid_i = 1'b0;

    // ---- HOLD stability, with a spurious rvalid while holding ----
    bus.m_req_i = 1'b1; bus.m_we_i = 1'b1; bus.m_be_i = 4'hF;
    bus.m_addr_i = 32'h400; bus.m_wdata_i = 32'hA5A5A5A5;
    push_m(1'b1, 4'hF, 32'h400, 32'hA5A5A5A5);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD00001;
      end
      neg();
      chk("hold_mem_req",   32'(bus.mem_req_o), 32'h1);
      chk("hold_mem_addr",  bus.mem_addr_o,     32'h400);
      chk("hold_mem_we",    32'(bus.mem_we_o),  32'h1);
      chk("hold_mem_wdata", bus.mem_wdata_o,    32'hA5A5A5A5);
      if (c == 1) begin
        chk("hold_spur_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
        chk("hold_spur_m_rvalid",  32'(bus.m_rvalid_o),  32'h0);
      end
      step();
      bus.mem_rvalid_i = 1'b0;
    end
    bus.mem_gnt_i = 1'b1;
    step();
    bus.m_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
    exp_m_q.push_back(32'h0);
    push_if(32'h500);
    step();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    step();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h11112222;
    exp_if_q.push_back(32'h11112222);
    step();
    bus.mem_rvalid_i = 1'b0;

    // ---- Starvation: both request continuously ----
    ia = 32'h1000; ma = 32'h2000;
    bus.if_req_i = 1'b1; bus.if_addr_i = ia;
    bus.m_req_i = 1'b1; bus.m_we_i = 1'b0; bus.m_be_i = 4'hF;
    bus.m_addr_i = ma; bus.m_wdata_i = 32'h0;
    for (int k = 0; k < 11; k++) begin
      bus.mem_gnt_i = 1'b1;
      if (starve_vec[k]) push_m(1'b0, 4'hF, ma, 32'h0);
      else push_if(ia);
      step();
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hC0DE0000 + 32'(k);
      later_if = 1'b0; later_m = 1'b0;
      for (int j = k + 1; j < 11; j++) begin
        if (starve_vec[j]) later_m = 1'b1;
        else later_if = 1'b1;
      end
      if (starve_vec[k]) begin
        exp_m_q.push_back(32'hC0DE0000 + 32'(k));
        ma = ma + 32'h4;
        bus.m_addr_i = ma; bus.m_req_i = later_m;
      end else begin
        exp_if_q.push_back(32'hC0DE0000 + 32'(k));
        ia = ia + 32'h4;
        bus.if_addr_i = ia; bus.if_req_i = later_if;
      end
      step();
      bus.mem_rvalid_i = 1'b0;
    end

    // ---- Spurious rvalid in IDLE ----
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD00002;
    neg();
    chk("spur_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("spur_m_rvalid",  32'(bus.m_rvalid_o),  32'h0);
    chk("spur_mem_req",   32'(bus.mem_req_o),   32'h0);
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h600; bus.mem_gnt_i = 1'b1;
    push_if(32'h600);
    neg();
    chk("spur_then_mem_req", 32'(bus.mem_req_o), 32'h1);
    step();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h600DF00D;
    exp_if_q.push_back(32'h600DF00D);
    step();
    bus.mem_rvalid_i = 1'b0;

    // ---- Reset mid-transaction ----
    bus.m_req_i = 1'b1; bus.m_we_i = 1'b0; bus.m_be_i = 4'hF;
    bus.m_addr_i = 32'h700; bus.m_wdata_i = 32'h0; bus.mem_gnt_i = 1'b1;
    push_m(1'b0, 4'hF, 32'h700, 32'h0);
    step();
    bus.m_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    rst_n = 1'b0;
    neg();
    chk("rmid_mem_req",   32'(bus.mem_req_o),   32'h0);
    chk("rmid_mem_we",    32'(bus.mem_we_o),    32'h0);
    chk("rmid_mem_be",    32'(bus.mem_be_o),    32'h0);
    chk("rmid_mem_addr",  bus.mem_addr_o,       32'h0);
    chk("rmid_mem_wdata", bus.mem_wdata_o,      32'h0);
    chk("rmid_if_gnt",    32'(bus.if_gnt_o),    32'h0);
    chk("rmid_m_gnt",     32'(bus.m_gnt_o),     32'h0);
    chk("rmid_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("rmid_m_rvalid",  32'(bus.m_rvalid_o),  32'h0);
    step();
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
    neg();
    chk("late_m_rvalid",  32'(bus.m_rvalid_o),  32'h0);
    chk("late_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h800; bus.mem_gnt_i = 1'b1;
    push_if(32'h800);
    step();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0BADCAFE;
    exp_if_q.push_back(32'h0BADCAFE);
    step();
    bus.mem_rvalid_i = 1'b0;
    step();
    step();

    // Every queued expectation must have been consumed
    chk("req_queue_empty",  32'(exp_req_q.size()), 32'h0);
    chk("if_queue_empty",   32'(exp_if_q.size()),  32'h0);
    chk("m_queue_empty",    32'(exp_m_q.size()),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single unified memory port between the IF stage (instruction fetch, read-only) and the M stage (load/store). Sits between the two pipeline stages and the memory interface. It arbitrates with M-over-IF priority plus an IF anti-starvation override, and keeps at most one transaction outstanding. It routes each response back to the requester that owns it.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive M grants won while IF is waiting before IF is forced to win; range 1..15

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  IF read request; held until if_gnt_o
- if_addr_i  in  ADDR_W  IF fetch address
- if_gnt_o  out  1  IF request accepted
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  DATA_W  IF read data
- m_req_i  in  1  M request; held until m_gnt_o
- m_we_i  in  1  1 = store, 0 = load
- m_be_i  in  DATA_W/8  byte enables
- m_addr_i  in  ADDR_W  M address
- m_wdata_i  in  DATA_W  store data
- m_gnt_o  out  1  M request accepted
- m_rvalid_o  out  1  M response (load data, or store completion)
- m_rdata_o  out  DATA_W  M load data
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory request
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response valid; arrives no earlier than 1 cycle after mem_gnt_i
- mem_rdata_i  in  DATA_W  memory response data

## Operation
FSM states:
- IDLE: no request presented, nothing outstanding.
  - If any request is present, select a winner (rules below) and present it on mem_* this same cycle. mem_req_o is combinational from the requests.
  - If mem_gnt_i=1 in the same cycle, go to WAIT_RESP. Otherwise register the selection and go to HOLD.
- HOLD: the registered selection drives mem_*. It stays stable until mem_gnt_i, even if the other requester raises req.
  - On mem_gnt_i, go to WAIT_RESP.
- WAIT_RESP: mem_req_o=0.
  - On mem_rvalid_i, forward the response to the owner and go to IDLE.

Grant and owner tracking:
- if_gnt_o = mem_gnt_i & mem_req_o & (selected==IF). m_gnt_o is formed the same way for M.
- The owner is registered on grant.
- Response routing: rdata_o of both requesters = mem_rdata_i (pass-through). Only the owner's rvalid_o is asserted.

Arbitration:
- Default: M wins over IF, because it serves the older instruction.
- Starvation counter (4 bits, saturating at STARVE_MAX):
  - Increments on each M grant while if_req_i=1.
  - Clears on any IF grant.
  - When it equals STARVE_MAX, IF wins the next arbitration.

Request fields:
- IF requests drive mem_we_o=0 and mem_be_o all ones.
- mem_wdata_o=0 whenever IF is selected.
- All mem_* outputs are 0 when mem_req_o=0.

Boundary conditions:
- Both requesters assert in the same cycle: M wins, unless the starvation counter has reached STARVE_MAX.
- mem_rvalid_i in IDLE or HOLD (spurious): ignored; no rvalid_o is asserted.
- Requester drops req before its grant: protocol violation. The bench flags it; the RTL need not recover.
- Reset while in HOLD or WAIT_RESP: the FSM returns to IDLE and the owner and counter clear. A late mem_rvalid_i after reset is dropped.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - All *_gnt_o, *_rvalid_o and mem_req_o read 0 while rst_i=0 with no requests.
  - mem_* and *_rdata_o follow their combinational sources.
- Grant latency: 0 cycles. A requester sees gnt in the same cycle as mem_gnt_i.
- Response latency: 0 cycles. *_rvalid_o is combinational from mem_rvalid_i in WAIT_RESP.
- No new request is issued in the cycle an rvalid arrives. Back-to-back throughput is at most 1 transaction per 2 cycles: grant in cycle N, rvalid in N+1, next request presented in N+2.
- Registered state: FSM, selection, owner, counter. Gnt/rvalid paths have no flop.

## Test plan
- Single IF fetch: if_req_i=1, addr 0x100, mem_gnt_i=1 in the same cycle, rvalid 2 cycles later with 0xDEADBEEF.
  - Required: if_gnt_o in cycle 0; mem_we_o=0 and mem_be_o=0xF; if_rvalid_o=1 and if_rdata_o=0xDEADBEEF in cycle 2; m_rvalid_o stays 0.
- Simultaneous requests: IF at 0x200, M store to 0x300 with wdata 0x12345678, be 0x3.
  - Required: M is presented and granted first, then M rvalid arrives, then IF is granted; mem_addr_o is 0x300 then 0x200.
- HOLD stability: M requests while mem_gnt_i=0 for 3 cycles, and IF raises req in cycle 1.
  - Required: mem_addr_o, mem_we_o and mem_wdata_o stay at the M values until mem_gnt_i.
- Starvation (STARVE_MAX=4): IF and M request continuously.
  - Required: exactly 4 M grants, then 1 IF grant, then the counter clears and the pattern repeats.
- Spurious rvalid: mem_rvalid_i=1 in IDLE.
  - Required: if_rvalid_o=m_rvalid_o=0 and the FSM stays in IDLE.
- Reset mid-transaction: grant an M load, then pull rst_i low for 1 cycle before rvalid.
  - Required: all outputs are 0; a following mem_rvalid_i produces no m_rvalid_o; the next IF request is served normally.
